// File: rtl/lc3b_types.sv
// lc3b_types: shared types for the LC-3b L1 instruction cache.
//   IC_NUM_SETS / IC_LINE_BYTES : default cache geometry
//   lc3b_icache_line            : one full cache line (8*IC_LINE_BYTES bits)
//   lc3b_icache_state           : miss-handling FSM states
package lc3b_types;

    localparam int IC_NUM_SETS   = 8;
    localparam int IC_LINE_BYTES = 16;

    typedef logic [8*IC_LINE_BYTES-1:0] lc3b_icache_line;

    typedef enum logic {
        ic_idle = 1'b0,
        ic_fill = 1'b1
    } lc3b_icache_state;

endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: valid/tag/data storage for a direct-mapped cache.
//   clk, reset_n          : clock, async active-low clear of all valid bits
//   i_rd_index            : set looked up combinationally
//   o_rd_valid/tag/line   : contents of the looked-up set
//   i_load                : write enable (one cycle)
//   i_wr_index/tag/line   : set, tag and line installed on i_load
module icache_line_array #(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = 3,
    parameter int TAG_W    = 9,
    parameter int LINE_W   = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  i_rd_index,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [LINE_W-1:0] o_rd_line,
    input  logic              i_load,
    input  logic [IDX_W-1:0]  i_wr_index,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LINE_W-1:0] i_wr_line
);

    logic [NUM_SETS-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [LINE_W-1:0]   r_data [NUM_SETS];

    // Only the valid bits need clearing; stale tag/data are masked by valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (i_load) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_line;
        end
    end

    // Asynchronous read so the fetch stage gets hits in the same cycle.
    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_line  = r_data[i_rd_index];

endmodule

// File: rtl/l1_icache.sv
// l1_icache: direct-mapped, read-only L1 instruction cache.
//   clk, reset_n              : clock, async active-low reset
//   imem_read/imem_address    : fetch request (address held until imem_resp)
//   imem_resp/imem_rdata      : same-cycle hit response, 16-bit word
//   pmem_read/pmem_address    : line-fill request, line-aligned address
//   pmem_resp/pmem_rdata      : one-cycle fill pulse with the whole line
//   hit_count/miss_count      : saturating hit-response / fill-start counters
module l1_icache
    import lc3b_types::*;
#(
    parameter int NUM_SETS   = IC_NUM_SETS,
    parameter int LINE_BYTES = IC_LINE_BYTES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    imem_read,
    input  logic [15:0]             imem_address,
    output logic                    imem_resp,
    output logic [15:0]             imem_rdata,
    output logic                    pmem_read,
    output logic [15:0]             pmem_address,
    input  logic                    pmem_resp,
    input  logic [8*LINE_BYTES-1:0] pmem_rdata,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
);

    localparam int OFS    = $clog2(LINE_BYTES);
    localparam int IDX    = $clog2(NUM_SETS);
    localparam int TAG_W  = 16 - OFS - IDX;
    localparam int LINE_W = 8 * LINE_BYTES;

    lc3b_icache_state r_state;
    logic             r_pmem_read;
    logic [15:0]      r_fill_addr;
    logic [15:0]      r_hit_count;
    logic [15:0]      r_miss_count;

    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [LINE_W-1:0] w_rd_line;
    logic [OFS-2:0]    w_word_sel;
    logic              w_hit;
    logic              w_load;
    logic              w_unused;

    icache_line_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX),
        .TAG_W    (TAG_W),
        .LINE_W   (LINE_W)
    ) u_lines (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_rd_index (imem_address[OFS+IDX-1:OFS]),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_line  (w_rd_line),
        .i_load     (w_load),
        .i_wr_index (r_fill_addr[OFS+IDX-1:OFS]),
        .i_wr_tag   (r_fill_addr[15:OFS+IDX]),
        .i_wr_line  (pmem_rdata)
    );

    // Hits are only recognised in IDLE; during a fill the request waits.
    assign w_hit      = (r_state == ic_idle) && imem_read && w_rd_valid
                        && (w_rd_tag == imem_address[15:OFS+IDX]);
    // Install only while a fill is outstanding, so a stray pmem_resp after
    // a reset is dropped.
    assign w_load     = (r_state == ic_fill) && pmem_resp;
    assign w_word_sel = imem_address[OFS-1:1];
    assign w_unused   = imem_address[0];

    assign imem_resp    = w_hit;
    assign imem_rdata   = w_hit ? w_rd_line[{w_word_sel, 4'b0000} +: 16] : 16'h0000;
    assign pmem_read    = r_pmem_read;
    assign pmem_address = r_fill_addr;
    assign hit_count    = r_hit_count;
    assign miss_count   = r_miss_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ic_idle;
            r_pmem_read  <= 1'b0;
            r_fill_addr  <= 16'h0000;
            r_hit_count  <= 16'h0000;
            r_miss_count <= 16'h0000;
        end else begin
            if (w_hit && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            case (r_state)
                ic_idle: begin
                    if (imem_read && !w_hit) begin
                        r_state     <= ic_fill;
                        r_pmem_read <= 1'b1;
                        // Latch the line address so the fill target stays
                        // fixed even if fetch redirects mid-fill.
                        r_fill_addr <= {imem_address[15:OFS], {OFS{1'b0}}};
                        if (r_miss_count != 16'hFFFF) begin
                            r_miss_count <= r_miss_count + 16'd1;
                        end
                    end
                end
                ic_fill: begin
                    if (pmem_resp) begin
                        r_state     <= ic_idle;
                        r_pmem_read <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ic_idle;
                    r_pmem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_icache.sv
module tb_l1_icache;

    localparam int NS = 8;
    localparam int LB = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          imem_read = 1'b0;
    logic [15:0]   imem_address = 16'h0000;
    logic          imem_resp;
    logic [15:0]   imem_rdata;
    logic          pmem_read;
    logic [15:0]   pmem_address;
    logic          pmem_resp = 1'b0;
    logic [8*LB-1:0] pmem_rdata = '0;
    logic [15:0]   hit_count;
    logic [15:0]   miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference counters, visible to the driver so it can mirror a poke.
    logic [15:0] m_hit  = 16'h0000;
    logic [15:0] m_miss = 16'h0000;

    l1_icache #(.NUM_SETS(NS), .LINE_BYTES(LB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word k of the line at base B is B + 0x1000 + k.
    function automatic logic [8*LB-1:0] mkline(input logic [15:0] base);
        logic [8*LB-1:0] l;
        l = '0;
        for (int k = 0; k < LB/2; k++) begin
            l[16*k +: 16] = base + 16'h1000 + 16'(k);
        end
        return l;
    endfunction

    // Behavioural model: each set remembers which line base it holds.
    initial begin
        bit              mvalid [NS];
        logic [15:0]     mbase  [NS];
        logic [8*LB-1:0] mline  [NS];
        bit              m_filling;
        logic [15:0]     m_fill_addr;
        int              idx;
        logic [15:0]     base;
        bit              hit;
        logic [8*LB-1:0] tmp;
        logic [15:0]     exp_rdata;
        m_filling   = 1'b0;
        m_fill_addr = 16'h0000;
        for (int s = 0; s < NS; s++) begin
            mvalid[s] = 1'b0;
            mbase[s]  = 16'h0000;
            mline[s]  = '0;
        end
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                for (int s = 0; s < NS; s++) mvalid[s] = 1'b0;
                m_filling = 1'b0;
                m_hit     = 16'h0000;
                m_miss    = 16'h0000;
            end
            idx  = (int'(imem_address) / LB) % NS;
            base = imem_address - 16'(int'(imem_address) % LB);
            hit  = reset_n && !m_filling && imem_read && mvalid[idx] && (mbase[idx] == base);
            tmp  = mline[idx] >> (16 * ((int'(imem_address) % LB) / 2));
            exp_rdata = hit ? tmp[15:0] : 16'h0000;

            chk("m_imem_resp", 16'(imem_resp), 16'(hit));
            chk("m_imem_rdata", imem_rdata, exp_rdata);
            chk("m_pmem_read", 16'(pmem_read), 16'(m_filling));
            if (m_filling) chk("m_pmem_address", pmem_address, m_fill_addr);
            chk("m_hit_count", hit_count, m_hit);
            chk("m_miss_count", miss_count, m_miss);

            if (reset_n) begin
                if (hit) begin
                    if (m_hit != 16'hFFFF) m_hit = m_hit + 16'd1;
                end else if (!m_filling && imem_read) begin
                    m_filling   = 1'b1;
                    m_fill_addr = base;
                    if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
                end else if (m_filling && pmem_resp) begin
                    idx         = (int'(m_fill_addr) / LB) % NS;
                    mvalid[idx] = 1'b1;
                    mbase[idx]  = m_fill_addr;
                    mline[idx]  = pmem_rdata;
                    m_filling   = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Miss on addr, answer after lat cycles in FILL, take the hit, drop the request.
    task automatic do_fill(input logic [15:0] addr, input int lat);
        imem_read = 1'b1;
        imem_address = addr;
        step();
        repeat (lat - 1) step();
        pmem_resp  = 1'b1;
        pmem_rdata = mkline(addr & 16'hFFF0);
        step();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        step();
        imem_read = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        #1;
        chk("rst_imem_resp", 16'(imem_resp), 16'h0000);
        chk("rst_imem_rdata", imem_rdata, 16'h0000);
        chk("rst_pmem_read", 16'(pmem_read), 16'h0000);
        chk("rst_hit_count", hit_count, 16'h0000);
        chk("rst_miss_count", miss_count, 16'h0000);
        reset_n = 1'b1;
        step();

        // Cold read
        imem_read = 1'b1;
        imem_address = 16'h0042;
        step();
        #1;
        chk("cold_pmem_read", 16'(pmem_read), 16'h0001);
        chk("cold_pmem_address", pmem_address, 16'h0040);
        chk("cold_miss_count", miss_count, 16'h0001);
        repeat (4) step();
        pmem_resp  = 1'b1;
        pmem_rdata = mkline(16'h0040);
        step();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1;
        chk("cold_resp", 16'(imem_resp), 16'h0001);
        chk("cold_rdata", imem_rdata, 16'h1041);

        // Same-line back-to-back hits
        step();
        imem_address = 16'h0040; #1;
        chk("hit_w0", imem_rdata, 16'h1040);
        step();
        imem_address = 16'h0044; #1;
        chk("hit_w2", imem_rdata, 16'h1042);
        step();
        imem_address = 16'h004E; #1;
        chk("hit_w7", imem_rdata, 16'h1047);
        step();
        imem_read = 1'b0; #1;
        chk("hits_hit_count", hit_count, 16'h0004);
        chk("hits_miss_count", miss_count, 16'h0001);
        step();

        // Conflict in set 4
        do_fill(16'h00C0, 2);
        step();
        do_fill(16'h0040, 3);
        #1;
        chk("conflict_miss_count", miss_count, 16'h0003);
        step();

        // Abandoned fill
        imem_read = 1'b1;
        imem_address = 16'h1230;
        step();
        imem_read = 1'b0;
        imem_address = 16'h5678;
        step();
        #1;
        chk("abandon_pmem_address", pmem_address, 16'h1230);
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = mkline(16'h1230);
        step();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        imem_read = 1'b1;
        imem_address = 16'h1232;
        #1;
        chk("abandon_hit_resp", 16'(imem_resp), 16'h0001);
        chk("abandon_hit_rdata", imem_rdata, 16'h2231);
        chk("abandon_no_pmem", 16'(pmem_read), 16'h0000);
        step();
        imem_read = 1'b0;
        step();

        // Hit counter saturation
        force dut.r_hit_count = 16'hFFFD;
        m_hit = 16'hFFFD;
        #1;
        release dut.r_hit_count;
        imem_read = 1'b1;
        imem_address = 16'h1232;
        repeat (3) step();
        imem_read = 1'b0;
        #1;
        chk("sat_hit_count", hit_count, 16'hFFFF);
        step();

        // Reset mid-fill
        imem_read = 1'b1;
        imem_address = 16'h2000;
        step();
        #1;
        chk("rstfill_pmem_before", 16'(pmem_read), 16'h0001);
        reset_n = 1'b0;
        #1;
        chk("rstfill_pmem_read", 16'(pmem_read), 16'h0000);
        imem_read = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = mkline(16'h2000);
        step();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        imem_read = 1'b1;
        imem_address = 16'h2000;
        #1;
        chk("stray_ignored_resp", 16'(imem_resp), 16'h0000);
        step();
        #1;
        chk("refetch_pmem_read", 16'(pmem_read), 16'h0001);
        chk("refetch_miss_count", miss_count, 16'h0001);
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = mkline(16'h2000);
        step();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        step();
        imem_address = 16'h1232;
        #1;
        chk("cleared_line_misses", 16'(imem_resp), 16'h0000);
        step();
        imem_read = 1'b0;
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = mkline(16'h1230);
        step();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
